// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// -----------------------------------------------------------------------------
// Sequencer for the PC and the IF/ID pipeline register of the 5-stage core.
//
// What it does
//   - Holds the front end idle until a start request arrives.
//   - Detects the classic load-use hazard and responds in the same cycle:
//     PC and IF/ID are frozen and a bubble is injected into ID/EX.
//   - Flushes IF/ID when a branch/jump resolves taken in ID.
//   - On a decoded halt, lets the halt instruction travel into EX, then spends
//     DRAIN_CYCLES cycles draining EX/MEM/WB before raising halt_o.
//   - Keeps two saturating performance counters (active cycles, stall cycles).
//
// Parameters
//   REG_W         register-specifier width
//   DRAIN_CYCLES  cycles spent in DRAIN after the halt leaves ID (>= 1)
//   CNT_W         performance-counter width
//
// Ports
//   clk_i           in   clock, all state updates on the rising edge
//   rst_i           in   synchronous reset, active-low
//   start_i         in   run request, only looked at while IDLE
//   idex_memread_i  in   instruction in EX is a load
//   idex_rt_i       in   destination register of the load in EX
//   ifid_rs_i       in   rs of the instruction in ID
//   ifid_rt_i       in   rt of the instruction in ID
//   branch_taken_i  in   branch/jump resolved taken in ID
//   halt_req_i      in   halt instruction decoded in ID
//   pchazard_o      out  1 = PC loads its next value, 0 = PC holds
//   ifid_write_o    out  IF/ID register write enable
//   ifid_flush_o    out  IF/ID register loads a NOP
//   idex_bubble_o   out  zero the control fields entering ID/EX
//   halt_o          out  pipeline drained and stopped (registered)
//   state_o         out  IDLE=0 RUN=1 DRAIN=2 HALTED=3
//   cycle_cnt_o     out  cycles spent in RUN or DRAIN (saturating)
//   stall_cnt_o     out  load-use stall cycles (saturating)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             branch_taken_i,
    input  logic             halt_req_i,
    output logic             pchazard_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             halt_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // The drain counter only ever holds DRAIN_CYCLES-1 down to 0.
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0] DRAIN_INIT = DRN_W'(DRAIN_CYCLES - 1);

    // Number of performance counters; index 0 = active cycles, 1 = stalls.
    localparam int NUM_CNT = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [DRN_W-1:0] drain_reg;
    logic [DRN_W-1:0] drain_next;

    logic             load_use;       // raw hazard condition, any state
    logic             stall_run;      // hazard actually acted on (RUN only)
    logic             active_cycle;   // RUN or DRAIN

    logic [NUM_CNT-1:0]            cnt_en;
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q;

    // -------------------------------------------------------------------------
    // Load-use hazard: the load in EX writes a register that the instruction
    // in ID reads. Register 0 is hard-wired zero, so it never creates a
    // dependency.
    // -------------------------------------------------------------------------
    assign load_use = idex_memread_i
                    && (idex_rt_i != '0)
                    && ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg <= ST_IDLE;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            drain_reg <= drain_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and front-end controls. The defaults are the "frozen" set
    // (PC hold, IF/ID held with a NOP, bubble into ID/EX) used by IDLE and
    // HALTED; RUN and DRAIN override what they need.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        drain_next    = drain_reg;
        pchazard_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
        stall_run     = 1'b0;
        active_cycle  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                active_cycle = 1'b1;
                if (load_use) begin
                    // Freeze PC and IF/ID so the dependent instruction is
                    // re-decoded next cycle; the load result is then
                    // forwardable. Branch and halt wait for that retry.
                    stall_run     = 1'b1;
                    pchazard_o    = 1'b0;
                    ifid_write_o  = 1'b0;
                    ifid_flush_o  = 1'b0;
                    idex_bubble_o = 1'b1;
                end else if (halt_req_i) begin
                    // The halt itself proceeds into EX; nothing behind it is
                    // allowed in, so PC holds and IF/ID takes a NOP.
                    pchazard_o    = 1'b0;
                    ifid_write_o  = 1'b1;
                    ifid_flush_o  = 1'b1;
                    idex_bubble_o = 1'b0;
                    state_next    = ST_DRAIN;
                    drain_next    = DRAIN_INIT;
                end else if (branch_taken_i) begin
                    // PC takes the branch target; the wrong-path fetch in
                    // IF is squashed.
                    pchazard_o    = 1'b1;
                    ifid_write_o  = 1'b1;
                    ifid_flush_o  = 1'b1;
                    idex_bubble_o = 1'b0;
                end else begin
                    pchazard_o    = 1'b1;
                    ifid_write_o  = 1'b1;
                    ifid_flush_o  = 1'b0;
                    idex_bubble_o = 1'b0;
                end
            end

            ST_DRAIN: begin
                // Only NOPs enter the pipe while the older instructions
                // retire; all hazard inputs are meaningless here.
                active_cycle  = 1'b1;
                pchazard_o    = 1'b0;
                ifid_write_o  = 1'b1;
                ifid_flush_o  = 1'b1;
                idex_bubble_o = 1'b1;
                if (drain_reg == '0) begin
                    state_next = ST_HALTED;
                end else begin
                    drain_next = drain_reg - DRN_W'(1);
                end
            end

            ST_HALTED: begin
                // Frozen defaults; only reset leaves this state.
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Saturating performance counters. Both share the same structure, so they
    // are built from one template; each stops at all-ones rather than wrap.
    // -------------------------------------------------------------------------
    assign cnt_en[0] = active_cycle;
    assign cnt_en[1] = stall_run;

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] count_reg;

            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    count_reg <= '0;
                end else if (cnt_en[gi] && (count_reg != {CNT_W{1'b1}})) begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end

            assign cnt_q[gi] = count_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs derived purely from registered state
    // -------------------------------------------------------------------------
    assign halt_o      = (state_reg == ST_HALTED);
    assign state_o     = state_reg;
    assign cycle_cnt_o = cnt_q[0];
    assign stall_cnt_o = cnt_q[1];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed stimulus with hand-computed expectations. Each stimulus step drives
// inputs just after a rising edge and queues what the DUT must show during
// that cycle; a monitor samples on the falling edge, pops and compares.
// A field expected as -1 is not compared. A second instance with CNT_W=4
// exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       memread;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       branch;
    logic       halt_req;

    logic        pchazard;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        halt;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;
    logic [31:0] stall_cnt;

    logic       rst4;
    logic       start4;
    logic       pchazard4;
    logic       ifid_write4;
    logic       ifid_flush4;
    logic       idex_bubble4;
    logic       halt4;
    logic [1:0] state4;
    logic [3:0] cycle_cnt4;
    logic [3:0] stall_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string nm;
        int    sel;   // 0 = main DUT, 1 = CNT_W=4 DUT
        int    pc;
        int    wr;
        int    fl;
        int    bb;
        int    hl;
        int    st;
        int    cyc;
        int    stl;
    } exp_t;

    exp_t sb[$];

    pipe_hazard_ctrl #(
        .REG_W        (5),
        .DRAIN_CYCLES (3),
        .CNT_W        (32)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .idex_memread_i (memread),
        .idex_rt_i      (ex_rt),
        .ifid_rs_i      (id_rs),
        .ifid_rt_i      (id_rt),
        .branch_taken_i (branch),
        .halt_req_i     (halt_req),
        .pchazard_o     (pchazard),
        .ifid_write_o   (ifid_write),
        .ifid_flush_o   (ifid_flush),
        .idex_bubble_o  (idex_bubble),
        .halt_o         (halt),
        .state_o        (state),
        .cycle_cnt_o    (cycle_cnt),
        .stall_cnt_o    (stall_cnt)
    );

    pipe_hazard_ctrl #(
        .REG_W        (5),
        .DRAIN_CYCLES (3),
        .CNT_W        (4)
    ) dut4 (
        .clk_i          (clk),
        .rst_i          (rst4),
        .start_i        (start4),
        .idex_memread_i (1'b0),
        .idex_rt_i      (5'd0),
        .ifid_rs_i      (5'd0),
        .ifid_rt_i      (5'd0),
        .branch_taken_i (1'b0),
        .halt_req_i     (1'b0),
        .pchazard_o     (pchazard4),
        .ifid_write_o   (ifid_write4),
        .ifid_flush_o   (ifid_flush4),
        .idex_bubble_o  (idex_bubble4),
        .halt_o         (halt4),
        .state_o        (state4),
        .cycle_cnt_o    (cycle_cnt4),
        .stall_cnt_o    (stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input int act, input int exp_v);
        if (exp_v >= 0) begin
            n_checks++;
            if (act != exp_v) begin
                n_fail++;
                $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, exp_v);
            end
        end
    endtask

    // Monitor: one popped transaction per falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == 0) begin
                chk(e.nm, "pchazard",    int'(pchazard),    e.pc);
                chk(e.nm, "ifid_write",  int'(ifid_write),  e.wr);
                chk(e.nm, "ifid_flush",  int'(ifid_flush),  e.fl);
                chk(e.nm, "idex_bubble", int'(idex_bubble), e.bb);
                chk(e.nm, "halt",        int'(halt),        e.hl);
                chk(e.nm, "state",       int'(state),       e.st);
                chk(e.nm, "cycle_cnt",   int'(cycle_cnt),   e.cyc);
                chk(e.nm, "stall_cnt",   int'(stall_cnt),   e.stl);
                $display("[%0t] %-10s st=%0d pc=%0b wr=%0b fl=%0b bb=%0b h=%0b cyc=%0d stl=%0d",
                         $time, e.nm, state, pchazard, ifid_write, ifid_flush,
                         idex_bubble, halt, cycle_cnt, stall_cnt);
            end else begin
                chk(e.nm, "state4",     int'(state4),     e.st);
                chk(e.nm, "cycle_cnt4", int'(cycle_cnt4), e.cyc);
                chk(e.nm, "stall_cnt4", int'(stall_cnt4), e.stl);
                $display("[%0t] %-10s st4=%0d cyc4=%0d stl4=%0d",
                         $time, e.nm, state4, cycle_cnt4, stall_cnt4);
            end
        end
    end

    // Drive one cycle of inputs on the main DUT and queue the expectation
    // for that same cycle (registered fields reflect the edge just passed).
    task automatic step(input string nm, input logic r, input logic s,
                        input logic mr, input logic [4:0] ert,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic br, input logic hr,
                        input int pc, input int wr, input int fl, input int bb,
                        input int hl, input int st, input int cyc, input int stl);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        start    = s;
        memread  = mr;
        ex_rt    = ert;
        id_rs    = rs;
        id_rt    = rt;
        branch   = br;
        halt_req = hr;
        e.nm = nm; e.sel = 0;
        e.pc = pc; e.wr = wr; e.fl = fl; e.bb = bb; e.hl = hl;
        e.st = st; e.cyc = cyc; e.stl = stl;
        sb.push_back(e);
    endtask

    task automatic step4(input string nm, input logic r, input logic s,
                         input int st, input int cyc);
        exp_t e;
        @(posedge clk);
        #1;
        rst4   = r;
        start4 = s;
        e.nm = nm; e.sel = 1;
        e.pc = -1; e.wr = -1; e.fl = -1; e.bb = -1; e.hl = -1;
        e.st = st; e.cyc = cyc; e.stl = 0;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; memread = 1'b0; ex_rt = '0;
        id_rs = '0; id_rt = '0; branch = 1'b0; halt_req = 1'b0;
        rst4 = 1'b0; start4 = 1'b0;

        //     name        rst st mr ert rs rt br hr   pc wr fl bb hl st cyc stl
        // --- reset and idle ---
        step("reset",      0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0, 0);
        rst4 = 1'b1;
        for (int i = 0; i < 10; i++)
            step("idle",   1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0, 0);
        step("start",      1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0, 0);
        step("run1",       1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 0, 0);
        // --- load-use ---
        step("lu_rs",      1, 0, 1, 8, 8, 0, 0, 0,   0, 0, 0, 1, 0, 1, 1, 0);
        step("after_lu",   1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 2, 1);
        step("lu_r0",      1, 0, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 3, 1);
        step("lu_rt",      1, 0, 1, 8, 3, 8, 0, 0,   0, 0, 0, 1, 0, 1, 4, 1);
        step("noload",     1, 0, 0, 8, 8, 8, 0, 0,   1, 1, 0, 0, 0, 1, 5, 2);
        // --- branch, priorities ---
        step("branch",     1, 0, 0, 0, 0, 0, 1, 0,   1, 1, 1, 0, 0, 1, 6, 2);
        step("br_lu",      1, 0, 1, 5, 5, 0, 1, 0,   0, 0, 0, 1, 0, 1, 7, 2);
        step("hl_lu",      1, 0, 1, 5, 0, 5, 1, 1,   0, 0, 0, 1, 0, 1, 8, 3);
        // --- halt and drain (halt cycle is T) ---
        step("halt_T",     1, 0, 0, 0, 0, 0, 1, 1,   0, 1, 1, 0, 0, 1, 9, 4);
        step("drain1",     1, 1, 1, 8, 8, 8, 1, 1,   0, 1, 1, 1, 0, 2, 10, 4);
        step("drain2",     1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 0, 2, 11, 4);
        step("drain3",     1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 0, 2, 12, 4);
        step("halted",     1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1, 3, 13, 4);
        step("halted2",    1, 0, 1, 8, 8, 8, 0, 0,   0, 0, 1, 1, 1, 3, 13, 4);
        step("halted3",    1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1, 3, 13, 4);
        // --- reset from HALTED, then reset in DRAIN ---
        step("rst_hlt",    0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1, 3, 13, 4);
        step("post_rst",   1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0, 0);
        step("run_b",      1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 0, 0);
        step("halt_b",     1, 0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 0, 1, 1, 0);
        step("drain_b",    0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 0, 2, 2, 0);
        step("rst_drn",    1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0, 0);
        step("idle_b",     1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0, 0);

        // --- saturation on the 4-bit counter instance ---
        step4("sat_rst",   0, 0, 0, 0);
        step4("sat_start", 1, 1, 0, 0);
        step4("sat_run0",  1, 0, 1, 0);
        for (int i = 1; i <= 20; i++)
            step4("sat_run",  1, 0, 1, (i < 15) ? i : 15);

        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_queue: got %0d pending, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
